// File: rtl/demux_1to3_router.sv
// demux_1to3_router: routes one WIDTH-bit word to one of three channels.
// Each channel has a one-entry holding register with a valid/ready handshake,
// so a stalled destination never blocks or corrupts the other two.
// Optional feature: define DEMUX_STATS_EN to add per-channel handshake
// counters cnt1..cnt3 (CNT_W bits, wrapping).
module demux_1to3_router #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       signal,
  output logic             out1_valid,
  output logic             out2_valid,
  output logic             out3_valid,
  input  logic             out1_ready,
  input  logic             out2_ready,
  input  logic             out3_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [WIDTH-1:0] out2_data,
  output logic [WIDTH-1:0] out3_data,
  output logic             sel_alias
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  ch_state_e        st_q   [3];
  logic [WIDTH-1:0] data_q [3];
  logic             sel_alias_q;

  logic [2:0] tgt_oh;
  logic [2:0] full;
  logic [2:0] rdy;
  logic [2:0] drain;
  logic       accept;

  // Decode destination select; values 2 and 3 both map to channel 3.
  always_comb begin
    tgt_oh = '0;
    unique case (signal)
      2'd0:    tgt_oh = 3'b001;
      2'd1:    tgt_oh = 3'b010;
      default: tgt_oh = 3'b100;
    endcase
  end

  // Per-channel occupancy, drain and the combinational accept decision.
  always_comb begin
    rdy = {out3_ready, out2_ready, out1_ready};
    for (int unsigned i = 0; i < 3; i++) begin
      full[i]  = (st_q[i] == FULL);
      drain[i] = full[i] & rdy[i];
    end
    // Target may take a word if empty or emptying this very cycle.
    in_ready = |(tgt_oh & (~full | drain));
    accept   = in_valid & in_ready;
  end

  // Channel FSMs and holding registers: load on accept, empty on drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) begin
        st_q[i]   <= EMPTY;
        data_q[i] <= '0;
      end
      sel_alias_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (accept && tgt_oh[i]) begin
          st_q[i]   <= FULL;
          data_q[i] <= in_data;
        end else if (drain[i]) begin
          st_q[i] <= EMPTY;
        end
      end
      sel_alias_q <= accept && (signal == 2'd3);
    end
  end

  assign out1_valid = (st_q[0] == FULL);
  assign out2_valid = (st_q[1] == FULL);
  assign out3_valid = (st_q[2] == FULL);
  assign out1_data  = data_q[0];
  assign out2_data  = data_q[1];
  assign out3_data  = data_q[2];
  assign sel_alias  = sel_alias_q;

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [3];

  // Count output handshakes per channel, wrapping at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (drain[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign cnt1 = cnt_q[0];
  assign cnt2 = cnt_q[1];
  assign cnt3 = cnt_q[2];
`endif

endmodule
